// File: rtl/ds2.sv
// ds2: two-input word selector for the CPU datapath, with a one-cycle
// registered copy of the selection and a change-detect pulse.
module ds2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             chg
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;
  logic             r_sel_q;
  logic             r_chg;

  // Unknown select falls into the else branch, so data1 is the default.
  always_comb begin
    w_out = data1;
    if (select == 1'b1) begin
      w_out = data2;
    end else begin
      w_out = data1;
    end
  end

  // Registered copy of the selection; chg flags a new value landing in out_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q <= {WIDTH{1'b0}};
      r_sel_q <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_out_q <= w_out;
      r_sel_q <= select;
      r_chg   <= (w_out != r_out_q);
    end
  end

  assign out   = w_out;
  assign out_q = r_out_q;
  assign sel_q = r_sel_q;
  assign chg   = r_chg;

endmodule

// File: tb/tb_ds2.sv
// Scoreboard bench for ds2: stimulus pushes per-cycle expectations, the monitor
// pops and compares them on each falling edge.
module tb_ds2;

  logic        clk;
  logic        rst_n;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        select;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_q;
  logic        chg;

  typedef struct packed {
    logic [31:0] e_out;
    logic [31:0] e_q;
    logic        e_sel;
    logic        e_chg;
    logic        chk_reg;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference state: what the registered outputs should hold after each edge.
  logic [31:0] m_q;
  logic        m_sel;
  logic        m_chg;
  bit          m_known;

  ds2 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data1 (data1),
    .data2 (data2),
    .select(select),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q),
    .chg   (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, queue this cycle's expectation, advance model.
  task automatic apply(input logic rn, input logic [31:0] d1, input logic [31:0] d2, input logic s);
    exp_t e;
    logic [31:0] sel_val;
    rst_n  = rn;
    data1  = d1;
    data2  = d2;
    select = s;
    sel_val = (s === 1'b1) ? d2 : d1;
    e.e_out   = sel_val;
    e.e_q     = m_q;
    e.e_sel   = m_sel;
    e.e_chg   = m_chg;
    e.chk_reg = m_known;
    sb.push_back(e);
    if (rn !== 1'b1) begin
      m_chg = 1'b0;
      m_q   = 32'd0;
      m_sel = 1'b0;
    end else begin
      m_chg = (sel_val != m_q);
      m_q   = sel_val;
      m_sel = s;
    end
    m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out", out, e.e_out);
      if (e.chk_reg) begin
        chk("out_q", out_q, e.e_q);
        chk("sel_q", {31'd0, sel_q}, {31'd0, e.e_sel});
        chk("chg", {31'd0, chg}, {31'd0, e.e_chg});
      end
    end
  end

  initial begin
    m_q     = 32'd0;
    m_sel   = 1'b0;
    m_chg   = 1'b0;
    m_known = 1'b0;
    rst_n   = 1'b0;
    data1   = 32'd0;
    data2   = 32'd0;
    select  = 1'b0;
    @(posedge clk);
    #1;

    // Directed sequence from the test plan.
    apply(1'b0, 32'h0, 32'h0, 1'b0);
    apply(1'b0, 32'h0, 32'h0, 1'b0);
    apply(1'b0, 32'h0, 32'h0, 1'b0);
    apply(1'b1, 32'h33, 32'h0, 1'b0);
    apply(1'b1, 32'h33, 32'hFF, 1'b0);
    apply(1'b1, 32'h33, 32'hFF, 1'b0);
    apply(1'b1, 32'h33, 32'hFF, 1'b1);
    apply(1'b1, 32'h33, 32'hFF, 1'b0);
    apply(1'b1, 32'h33, 32'hFF, 1'b0);
    apply(1'b1, 32'h33, 32'hFF, 1'b0);
    apply(1'b1, 32'hFFFFFFFF, 32'hFF, 1'b0);
    apply(1'b1, 32'hFFFFFFFF, 32'hFF, 1'b0);
    apply(1'b0, 32'hFFFFFFFF, 32'hFF, 1'b0);
    apply(1'b0, 32'hFFFFFFFF, 32'hFF, 1'b0);
    // Unknown select during reset must fall back to data1.
    apply(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'bx);
    apply(1'b1, 32'h0, 32'h12345678, 1'b1);
    apply(1'b1, 32'h0, 32'h12345678, 1'b1);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      logic        rn;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        s;
      rn = ($urandom_range(0, 19) != 0);
      d1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      d2 = ($urandom_range(0, 3) == 0) ? d1 : $urandom;
      s  = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        // Hold previous inputs to exercise chg deassertion.
        d1 = data1;
        d2 = data2;
        s  = select;
        rn = 1'b1;
      end
      apply(rn, d1, d2, s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
